// File: rtl/ds_arbiter_pkg.sv
// ds_arbiter_pkg
//   Shared definitions for the data-store arbiter: access-mode encodings,
//   arbiter FSM state encoding and the default parameter values.
//   No ports; imported by ds_arbiter.

package ds_arbiter_pkg;

  // Default geometry of the shared data store and the starvation bound.
  localparam int DEF_AWIDTH     = 12;
  localparam int DEF_DWIDTH     = 32;
  localparam int DEF_STARVE_MAX = 4;

  // Access size encodings understood by the data store.
  typedef enum logic [1:0] {
    MODE_WORD    = 2'b00,
    MODE_BYTE    = 2'b01,
    MODE_HALF    = 2'b10,
    MODE_ILLEGAL = 2'b11
  } mode_e;

  // Arbiter states. IDLE: nothing buffered; WAIT: B request buffered but
  // not yet given the store; SERVE: B owns the store this cycle.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WAIT  = 2'b01,
    ST_SERVE = 2'b10
  } state_e;

  // Mode 11 selects no byte lanes, so a B access using it must not write.
  function automatic logic mode_is_legal(input logic [1:0] mode);
    return mode != MODE_ILLEGAL;
  endfunction

endpackage

// File: rtl/ds_arbiter.sv
// ds_arbiter
//   Arbitrates one shared data store between the pipeline MEM stage (port A,
//   priority) and a secondary loader/debug port (port B, one-entry buffer).
//   A pending B request is served as soon as A is idle, or after A has been
//   granted STARVE_MAX times while B waited; in that cycle A is stalled.
//
// Ports
//   clk, clr                        clock, synchronous active-high reset
//   a_req, a_we, a_mode, a_addr,
//   a_wdata                         A request (held by the pipeline)
//   a_gnt, a_stall, a_rdata         A served / A must hold / A read data
//   b_req, b_we, b_mode, b_addr,
//   b_wdata                         B request, single-cycle pulse
//   b_ready                         B buffer empty, b_req accepted
//   b_done, b_err, b_rdata          B completion pulse, illegal-mode flag,
//                                   registered B read data
//   mem_str, mem_mode, mem_addr,
//   mem_din, mem_dout               data-store port

module ds_arbiter
  import ds_arbiter_pkg::*;
#(
  parameter int AWIDTH     = DEF_AWIDTH,
  parameter int DWIDTH     = DEF_DWIDTH,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk,
  input  logic              clr,

  input  logic              a_req,
  input  logic              a_we,
  input  logic [1:0]        a_mode,
  input  logic [AWIDTH-1:0] a_addr,
  input  logic [DWIDTH-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_stall,
  output logic [DWIDTH-1:0] a_rdata,

  input  logic              b_req,
  input  logic              b_we,
  input  logic [1:0]        b_mode,
  input  logic [AWIDTH-1:0] b_addr,
  input  logic [DWIDTH-1:0] b_wdata,
  output logic              b_ready,
  output logic              b_done,
  output logic              b_err,
  output logic [DWIDTH-1:0] b_rdata,

  output logic              mem_str,
  output logic [1:0]        mem_mode,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_din,
  input  logic [DWIDTH-1:0] mem_dout
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  state_e            state;
  state_e            cur_state;
  logic              b_pend;
  logic              accept;
  logic              starved;
  logic              serve;
  logic              buf_legal;
  logic [CW-1:0]     starve_cnt;

  logic              buf_we;
  logic [1:0]        buf_mode;
  logic [AWIDTH-1:0] buf_addr;
  logic [DWIDTH-1:0] buf_wdata;

  assign b_pend    = (state == ST_WAIT);
  assign b_ready   = ~b_pend;
  assign accept    = ~clr & b_req & b_ready;
  assign starved   = (starve_cnt == CW'(STARVE_MAX));
  assign buf_legal = mode_is_legal(buf_mode);

  // The serve decision depends on this cycle's a_req, so SERVE is resolved
  // within the cycle from the registered WAIT state rather than registered
  // itself. This lets B take the store in the very cycle after acceptance
  // when A is idle, and lets A keep exactly STARVE_MAX grants otherwise.
  assign serve = ~clr & (state == ST_WAIT) & (~a_req | starved);

  always_comb begin
    cur_state = state;
    if (serve) begin
      cur_state = ST_SERVE;
    end
  end

  // A sees the store's read data directly; it is only meaningful with a_gnt.
  assign a_rdata = mem_dout;

  // Port mux: the store follows A unless B is being served. Reset blocks
  // every write and every grant.
  always_comb begin
    a_gnt    = 1'b0;
    a_stall  = 1'b0;
    mem_str  = 1'b0;
    mem_mode = a_mode;
    mem_addr = a_addr;
    mem_din  = a_wdata;
    if (cur_state == ST_SERVE) begin
      a_stall  = a_req;
      mem_mode = buf_mode;
      mem_addr = buf_addr;
      mem_din  = buf_wdata;
      mem_str  = buf_we & buf_legal;
    end else if (!clr) begin
      a_gnt   = a_req;
      mem_str = a_req & a_we;
    end
  end

  // Arbiter FSM with the B buffer, starvation counter and registered
  // completion outputs. The buffer has no reset: it is only read in WAIT.
  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= ST_IDLE;
      starve_cnt <= '0;
      b_done     <= 1'b0;
      b_err      <= 1'b0;
      b_rdata    <= '0;
    end else begin
      b_done <= 1'b0;
      b_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            buf_we     <= b_we;
            buf_mode   <= b_mode;
            buf_addr   <= b_addr;
            buf_wdata  <= b_wdata;
            starve_cnt <= '0;
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (serve) begin
            b_done     <= 1'b1;
            b_err      <= ~buf_legal;
            b_rdata    <= buf_legal ? mem_dout : '0;
            starve_cnt <= '0;
            state      <= ST_IDLE;
          end else if (a_gnt && !starved) begin
            starve_cnt <= starve_cnt + CW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
